// File: rtl/dm_block_mover.sv
// Data-memory bus master that copies (overlap-safe, memmove order) or fills a block of N words.
// Shares the DM port with the datapath through an external mux selected by busy.
module dm_block_mover #(
    parameter int MAX_INDEX = 4096,
    parameter int LEN_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic              mode_q;
    logic              desc_q;
    logic [31:0]       src_ptr;
    logic [31:0]       dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [31:0]       fill_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;

    // Block bounds are evaluated in 33 bits so a block near 2^32 cannot wrap past the limit.
    logic [32:0] len_ext;
    logic [32:0] src_end;
    logic [32:0] dst_end;
    logic        range_err;
    logic        descending;
    logic [31:0] src_next;
    logic [31:0] dst_next;

    assign len_ext    = {{(33-LEN_W){1'b0}}, remaining};
    assign src_end    = {1'b0, src_ptr} + len_ext - 33'd1;
    assign dst_end    = {1'b0, dst_ptr} + len_ext - 33'd1;
    assign range_err  = (dst_end > 33'(MAX_INDEX)) || (!mode_q && (src_end > 33'(MAX_INDEX)));
    // A destination that starts inside the source block must be written from the top down.
    assign descending = !mode_q && (dst_ptr > src_ptr) && ({1'b0, dst_ptr} < ({1'b0, src_ptr} + len_ext));
    assign src_next   = desc_q ? src_ptr - 32'd1 : src_ptr + 32'd1;
    assign dst_next   = desc_q ? dst_ptr - 32'd1 : dst_ptr + 32'd1;

    // NOTE: the write strobe is gated combinationally by reset so a reset edge can never commit a write.
    assign mem_we    = we_q & ~reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            desc_q    <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            fill_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        fill_q    <= fill_val;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if ((remaining == '0) || range_err) begin
                        err   <= (remaining != '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        desc_q  <= descending;
                        src_ptr <= descending ? src_end[31:0] : src_ptr;
                        dst_ptr <= descending ? dst_end[31:0] : dst_ptr;
                        if (mode_q) begin
                            addr_q  <= dst_ptr;
                            wdata_q <= fill_q;
                            we_q    <= 1'b1;
                            state   <= S_WRITE;
                        end else begin
                            addr_q <= descending ? src_end[31:0] : src_ptr;
                            state  <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    wdata_q <= mem_rdata;
                    addr_q  <= dst_ptr;
                    we_q    <= 1'b1;
                    state   <= S_WRITE;
                end

                S_WRITE: begin
                    remaining <= remaining - LEN_W'(1);
                    src_ptr   <= src_next;
                    dst_ptr   <= dst_next;
                    if (remaining == LEN_W'(1)) begin
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (mode_q) begin
                        addr_q <= dst_next;
                    end else begin
                        we_q   <= 1'b0;
                        addr_q <= src_next;
                        state  <= S_READ;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_block_mover.sv
// Self-checking bench for dm_block_mover: directed scenarios plus randomized ops checked
// against a memmove/fill reference model operating on a shadow copy of data memory.
module tb_dm_block_mover;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [12:0] len;
    logic [31:0] fill_val;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dm_block_mover dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Data memory seen by the DUT; only this process writes it (preload port or DUT writes).
    logic [31:0] dm      [0:8191];
    logic [31:0] exp_mem [0:8191];
    logic [31:0] wr_addr_q [$];
    logic [31:0] exp_wr_q  [$];
    logic        pre_we;
    logic [12:0] pre_addr;
    logic [31:0] pre_data;

    assign mem_rdata = (mem_addr < 32'd8192) ? dm[mem_addr[12:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 32'd8192) dm[mem_addr[12:0]] <= mem_wdata;
            wr_addr_q.push_back(mem_addr);
        end
        if (pre_we) dm[pre_addr] <= pre_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   op_base;
    int   op_done;
    logic op_err;
    int   op_busy_bad;
    int   exp_done;
    logic exp_err;

    task automatic pre_write(input int a, input logic [31:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = 13'(a);
        pre_data = v;
        exp_mem[a] = v;
    endtask

    task automatic pre_end();
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 768; i++) if (dm[i] !== exp_mem[i]) n++;
        for (int i = 4064; i < 4128; i++) if (dm[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    function automatic int wr_mismatch(input int base);
        if (wr_addr_q.size() - base != exp_wr_q.size()) return 1;
        for (int i = 0; i < exp_wr_q.size(); i++)
            if (wr_addr_q[base + i] !== exp_wr_q[i]) return 1;
        return 0;
    endfunction

    // Reference: whole-block memmove (or fill) applied to the shadow memory in one step.
    task automatic model_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [31:0] f);
        longint      ls = longint'(s);
        longint      ld = longint'(d);
        logic [31:0] tmp [$];
        exp_wr_q.delete();
        exp_err = (n != 0) && ((ld + n - 1 > 4096) || (!m && (ls + n - 1 > 4096)));
        if (n == 0 || exp_err) begin
            exp_done = 2;
        end else begin
            exp_done = m ? 2 + n : 2 + 2 * n;
            for (int i = 0; i < n; i++) tmp.push_back(m ? f : exp_mem[int'(s) + i]);
            for (int i = 0; i < n; i++) exp_mem[int'(d) + i] = tmp[i];
            if (!m && ld > ls && ld < ls + n)
                for (int i = n - 1; i >= 0; i--) exp_wr_q.push_back(d + 32'(i));
            else
                for (int i = 0; i < n; i++) exp_wr_q.push_back(d + 32'(i));
        end
    endtask

    // Drives one start pulse and watches until done or the cycle limit; cycle 1 follows the accept edge.
    task automatic run_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [12:0] n, input logic [31:0] f, input int limit);
        op_base = wr_addr_q.size();
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = n; fill_val = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; len = 13'($urandom); fill_val = $urandom; mode = ~m;
        op_done = -1; op_err = 1'bx; op_busy_bad = 0;
        for (int c = 1; c <= limit; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                op_done = c;
                op_err  = err;
                if (busy !== 1'b0) op_busy_bad++;
                break;
            end
            if (busy !== 1'b1) op_busy_bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: busy/done/err/we=%b required 0000", {busy, done, err, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %0h required 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %0h required 0", mem_wdata);
        end
    endtask

    task automatic init_memory();
        for (int i = 0; i < 768; i++) pre_write(i, $urandom);
        for (int i = 4064; i < 4128; i++) pre_write(i, $urandom);
        pre_end();
    endtask

    task automatic test_copy_ascending();
        int bad = 0;
        for (int i = 0; i < 4; i++) pre_write(16 + i, 32'hA0 + 32'(i));
        pre_end();
        model_op(1'b0, 16, 100, 4, 0);
        run_op(1'b0, 16, 100, 4, 0, 20);
        checks++;
        if (op_done !== 10 || op_err !== 1'b0) begin
            errors++; $display("FAIL copy_asc_done: cycle %0d err %b required cycle 10 err 0", op_done, op_err);
        end
        checks++;
        if (op_busy_bad !== 0) begin
            errors++; $display("FAIL copy_asc_busy: %0d bad busy cycles required 0", op_busy_bad);
        end
        if (wr_addr_q.size() - op_base != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (wr_addr_q[op_base + i] !== 32'(100 + i)) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL copy_asc_order: %0d writes required 4 at 100..103", wr_addr_q.size() - op_base);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (dm[100 + i] !== 32'hA0 + 32'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL copy_asc_data: %0d wrong words required DM[100..103]=A0..A3", bad);
        end
    endtask

    task automatic test_overlap_descending();
        int bad = 0;
        for (int i = 0; i < 5; i++) pre_write(10 + i, 32'(i + 1));
        pre_end();
        model_op(1'b0, 10, 12, 5, 0);
        run_op(1'b0, 10, 12, 5, 0, 25);
        checks++;
        if (op_done !== 12 || op_err !== 1'b0) begin
            errors++; $display("FAIL overlap_done: cycle %0d err %b required cycle 12 err 0", op_done, op_err);
        end
        if (wr_addr_q.size() - op_base != 5) bad = 1;
        else for (int i = 0; i < 5; i++) if (wr_addr_q[op_base + i] !== 32'(16 - i)) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL overlap_order: %0d writes required 5 at 16 down to 12", wr_addr_q.size() - op_base);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (dm[12 + i] !== 32'(i + 1)) bad++;
        if (dm[10] !== 32'd1 || dm[11] !== 32'd2) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL overlap_data: %0d wrong words required DM[10..16]=1,2,1..5", bad);
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        model_op(1'b1, 0, 4090, 7, 32'hDEADBEEF);
        run_op(1'b1, 32'h5, 4090, 7, 32'hDEADBEEF, 20);
        checks++;
        if (op_done !== 9 || op_err !== 1'b0) begin
            errors++; $display("FAIL fill_done: cycle %0d err %b required cycle 9 err 0", op_done, op_err);
        end
        checks++;
        if (op_busy_bad !== 0) begin
            errors++; $display("FAIL fill_busy: %0d bad busy cycles required 0", op_busy_bad);
        end
        if (wr_addr_q.size() - op_base != 7) bad = 1;
        else for (int i = 0; i < 7; i++) if (wr_addr_q[op_base + i] !== 32'(4090 + i)) bad = 1;
        for (int i = 0; i < 7; i++) if (dm[4090 + i] !== 32'hDEADBEEF) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL fill_data: %0d writes or data wrong, required DM[4090..4096]=DEADBEEF", wr_addr_q.size() - op_base);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL fill_done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_range_error();
        run_op(1'b1, 0, 4095, 3, 32'h1111, 10);
        checks++;
        if (op_done !== 2 || op_err !== 1'b1 || wr_addr_q.size() != op_base) begin
            errors++; $display("FAIL range_dst: cycle %0d err %b writes %0d required cycle 2 err 1 writes 0",
                               op_done, op_err, wr_addr_q.size() - op_base);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL range_err_hold: err=%b in idle required 1", err);
        end
        run_op(1'b0, 4095, 0, 3, 0, 10);
        checks++;
        if (op_done !== 2 || op_err !== 1'b1 || wr_addr_q.size() != op_base) begin
            errors++; $display("FAIL range_src: cycle %0d err %b writes %0d required cycle 2 err 1 writes 0",
                               op_done, op_err, wr_addr_q.size() - op_base);
        end
        model_op(1'b1, 0, 4094, 3, 32'h2222);
        run_op(1'b1, 0, 4094, 3, 32'h2222, 10);
        checks++;
        if (op_done !== 5 || op_err !== 1'b0 || wr_addr_q.size() - op_base != 3) begin
            errors++; $display("FAIL range_exact_fit: cycle %0d err %b writes %0d required cycle 5 err 0 writes 3",
                               op_done, op_err, wr_addr_q.size() - op_base);
        end
    endtask

    task automatic test_zero_len();
        run_op(1'b0, 20, 30, 0, 0, 10);
        checks++;
        if (op_done !== 2 || op_err !== 1'b0 || wr_addr_q.size() != op_base) begin
            errors++; $display("FAIL zero_len: cycle %0d err %b writes %0d required cycle 2 err 0 writes 0",
                               op_done, op_err, wr_addr_q.size() - op_base);
        end
        checks++;
        if (mem_diffs() != 0) begin
            errors++; $display("FAIL directed_memory: %0d words differ from model, required 0", mem_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int base = wr_addr_q.size();
        @(negedge clk);
        mode = 1'b0; src_addr = 300; dst_addr = 400; len = 8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd402) begin
            errors++; $display("FAIL reset_mid_third_write: we=%b addr=%0d required we=1 addr=402", mem_we, mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy: busy=%b done=%b required 0 0", busy, done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_mem[400] = exp_mem[300];
        exp_mem[401] = exp_mem[301];
        checks++;
        if (wr_addr_q.size() - base != 2 || busy !== 1'b0 || mem_diffs() != 0) begin
            errors++; $display("FAIL reset_mid_writes: %0d writes busy=%b diffs=%0d required 2 writes busy 0 diffs 0",
                               wr_addr_q.size() - base, busy, mem_diffs());
        end
    endtask

    task automatic test_start_while_busy();
        int base = wr_addr_q.size();
        int done_c = -1;
        int bad = 0;
        model_op(1'b0, 500, 600, 4, 0);
        @(negedge clk);
        mode = 1'b0; src_addr = 500; dst_addr = 600; len = 4; fill_val = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 3) begin
                start = 1'b1; mode = 1'b1; src_addr = 0; dst_addr = 700; len = 2; fill_val = 32'h12345678;
            end
            if (c == 4) start = 1'b0;
            if (done === 1'b1) begin done_c = c; break; end
        end
        checks++;
        if (done_c !== 10 || err !== 1'b0) begin
            errors++; $display("FAIL busy_start_done: cycle %0d err %b required cycle 10 err 0", done_c, err);
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL done_start_ignored: busy=%b after start in DONE, required 0", busy);
        end
        start = 1'b0;
        @(negedge clk);
        if (wr_addr_q.size() - base != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (wr_addr_q[base + i] !== 32'(600 + i)) bad = 1;
        checks++;
        if (bad != 0 || mem_diffs() != 0) begin
            errors++; $display("FAIL busy_start_writes: %0d writes diffs=%0d required 4 at 600..603 diffs 0",
                               wr_addr_q.size() - base, mem_diffs());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            logic        m = 1'($urandom_range(0, 1));
            int          n = $urandom_range(0, 20);
            int          s = $urandom_range(0, 300);
            int          d = $urandom_range(0, 300);
            logic [31:0] f = $urandom;
            case ($urandom_range(0, 4))
                1: d = s + $urandom_range(1, 5);
                2: d = (s >= 5) ? s - $urandom_range(0, 5) : s;
                3: d = 4080 + $urandom_range(0, 20);
                4: s = 4085 + $urandom_range(0, 15);
                default: ;
            endcase
            model_op(m, 32'(s), 32'(d), n, f);
            run_op(m, 32'(s), 32'(d), 13'(n), f, 2 * n + 8);
            checks++;
            if (op_done !== exp_done || op_err !== exp_err) begin
                errors++; $display("FAIL rand%0d_done: cycle %0d err %b required cycle %0d err %b (m=%b s=%0d d=%0d n=%0d)",
                                   k, op_done, op_err, exp_done, exp_err, m, s, d, n);
            end
            checks++;
            if (op_busy_bad !== 0) begin
                errors++; $display("FAIL rand%0d_busy: %0d bad busy cycles required 0", k, op_busy_bad);
            end
            checks++;
            if (wr_mismatch(op_base) != 0) begin
                errors++; $display("FAIL rand%0d_order: %0d writes required %0d in memmove order (m=%b s=%0d d=%0d n=%0d)",
                                   k, wr_addr_q.size() - op_base, exp_wr_q.size(), m, s, d, n);
            end
            checks++;
            if (mem_diffs() != 0) begin
                errors++; $display("FAIL rand%0d_memory: %0d words differ required 0", k, mem_diffs());
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        test_reset();
        init_memory();
        @(negedge clk);
        reset = 1'b0;
        test_copy_ascending();
        test_overlap_descending();
        test_fill();
        test_range_error();
        test_zero_len();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
